// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit blocks.
//   sched_state_t      - states of the transmit scheduler FSM
//   DEFAULT_DATA_WIDTH - bits per UART character
//   DEFAULT_OVERSAMPLE - baud_tick pulses per UART bit time
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        - request vector, one bit per requester
//   last_grant - index granted most recently; search starts one above it
//   grant_idx  - first set request found at last_grant+1, +2, ... mod NUM_REQ
//   any_req    - at least one request bit is set (grant_idx valid only then)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  // One extra bit so last_grant + i (at most 2*NUM_REQ-1) never overflows
  // before the single wrap subtraction.
  logic [IW:0] cand;
  logic        found;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmit datapath between NUM_REQ
// byte-stream requesters with round-robin bursts and an idle gap per frame.
//   clk, rst_n   - clock, asynchronous active-low reset
//   baud_tick    - one-cycle pulse, OVERSAMPLE per bit time (times the gap)
//   req_valid    - per-requester byte available
//   req_data     - requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     - current byte ends the requester's burst
//   req_ready    - one-hot byte accept (combinational, only in SEND)
//   tx_start     - registered one-cycle pulse launching a frame
//   tx_data      - registered byte, stable from tx_start until next accept
//   tx_busy      - datapath frame in progress
//   grant_id     - current or most recent grantee
//   grant_active - a grant is held
//   dbg_state    - current FSM state
//
// Handshake: a requester byte transfers on a rising edge where
// req_valid[i] && req_ready[i]; req_ready never depends on anything but
// state, grant_id and req_valid, and a requester must hold data/last stable
// while valid is high and not yet accepted.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 16,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int GAP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active,
  output sched_state_t                  dbg_state
);

  localparam int IW        = $clog2(NUM_REQ);
  localparam int BW        = $clog2(MAX_BURST + 1);
  localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
  localparam int GW        = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST  = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  sched_state_t          state, state_nxt;
  logic [IW-1:0]         last_grant;
  logic [BW-1:0]         burst_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  last_flag;
  logic [IW-1:0]         arb_idx;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept, grant_take, release_grant;
  logic                  release_cond, gap_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_idx  (arb_idx),
    .any_req    (any_req)
  );

  assign sel_data     = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign release_cond = last_flag || (burst_cnt == BW'(MAX_BURST));
  assign gap_done     = (state == GAP) && baud_tick && (gap_cnt == GW'(GAP_LAST));
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    accept        = 1'b0;
    grant_take    = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_take = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        // A stalled grantee forfeits its turn rather than blocking others.
        if (req_valid[grant_id]) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_nxt           = WAIT_BUSY;
        end else begin
          release_grant = 1'b1;
          state_nxt     = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_BITS > 0) begin
            state_nxt = GAP;
          end else if (release_cond) begin
            release_grant = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          if (release_cond) begin
            release_grant = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      last_grant   <= IW'(NUM_REQ - 1);
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      last_flag    <= 1'b0;
    end else begin
      tx_start <= accept;
      if (accept) begin
        tx_data   <= sel_data;
        last_flag <= req_last[grant_id];
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (grant_take) begin
        grant_id     <= arb_idx;
        grant_active <= 1'b1;
        burst_cnt    <= '0;
      end
      if (release_grant) begin
        last_grant   <= grant_id;
        grant_active <= 1'b0;
      end
      if ((state == GAP) && baud_tick) begin
        gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: self-checking bench for uart_tx_scheduler with
// requester queues, a behavioural transmit datapath and an expected queue
// of {grant_id, byte} checked on every tx_start.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DW         = 8;
  localparam int MAX_BURST  = 16;
  localparam int OVERSAMPLE = 16;
  localparam int GAP_BITS   = 1;
  localparam int IW         = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 baud_tick = 1'b0;
  logic                 tx_busy = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [DW-1:0]        tx_data;
  logic [IW-1:0]        grant_id;
  logic                 grant_active;
  sched_state_t         dbg_state;

  int vectors = 0;
  int errors = 0;
  int ready_cnt = 0;
  int start_cnt = 0;
  logic long_busy = 1'b0;

  logic [IW+DW-1:0] exp_q[$];
  logic [DW:0]      src_q[NUM_REQ][$];

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST),
    .OVERSAMPLE(OVERSAMPLE), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .grant_active(grant_active),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic src_push(input int r, input logic last, input logic [DW-1:0] d);
    src_q[r].push_back({last, d});
  endtask

  task automatic exp_push(input int r, input logic [DW-1:0] d);
    exp_q.push_back({IW'(r), d});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (n < limit && !(exp_q.size() == 0 && !grant_active && !tx_busy && req_valid == '0)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < limit), 1);
  endtask

  // baud tick: one-cycle pulse every second clock
  initial begin
    forever begin
      @(posedge clk);
      #1 baud_tick = ~baud_tick;
    end
  end

  // requester models: present queue heads, pop on handshake
  logic [NUM_REQ-1:0] hs;
  logic [DW:0]        head;
  initial begin
    forever begin
      @(negedge clk);
      hs = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          head = src_q[i][0];
          req_valid[i]          = 1'b1;
          req_last[i]           = head[DW];
          req_data[i*DW +: DW]  = head[DW-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // behavioural transmit datapath
  initial begin
    int d, len;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        d   = $urandom_range(0, 2);
        len = long_busy ? 5000 : $urandom_range(3, 10);
        repeat (1 + d) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic             prev_start;
    logic [IW+DW-1:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ready != '0) begin
          ready_cnt++;
          check("ready_onehot", 32'($onehot(req_ready)), 1);
          check("ready_needs_valid", 32'((req_ready & ~req_valid) == '0), 1);
        end
        if (tx_start) begin
          start_cnt++;
          check("start_width", 32'(prev_start), 0);
          check("sb_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_grant_id", 32'(grant_id), 32'(e[IW+DW-1:DW]));
            check("tx_data", 32'(tx_data), 32'(e[DW-1:0]));
          end
        end
        prev_start = tx_start;
      end else begin
        prev_start = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  int n, ticks, r0, s0;
  logic found;
  logic [DW-1:0] dd[24];
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_grant_active", 32'(grant_active), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single byte from requester 0, gap timing
    r0 = ready_cnt; s0 = start_cnt;
    src_push(0, 1'b1, 8'h55); exp_push(0, 8'h55);
    n = 0;
    while (n < 20 && !req_ready[0]) begin @(negedge clk); n++; end
    check("t1_ready_seen", 32'(req_ready[0]), 1);
    @(negedge clk);
    check("t1_start_next", 32'(tx_start), 1);
    check("t1_data", 32'(tx_data), 32'h55);
    n = 0;
    while (n < 20 && !tx_busy) begin @(negedge clk); n++; end
    check("t1_busy_rise", 32'(tx_busy), 1);
    n = 0;
    while (n < 50 && tx_busy) begin @(negedge clk); n++; end
    check("t1_busy_fall", 32'(tx_busy), 0);
    ticks = 0; n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (!grant_active) break;
      if (baud_tick) ticks++;
    end
    check("t1_gap_ticks", 32'(ticks), 16);
    wait_idle("t1_idle", 200);
    check("t1_ready_pulses", 32'(ready_cnt - r0), 1);
    check("t1_starts", 32'(start_cnt - s0), 1);

    // all four requesters, one-byte bursts: order 0,1,2,3,0
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) dd[i] = DW'($urandom_range(0, 255));
    src_push(0, 1'b1, dd[0]); src_push(0, 1'b1, dd[4]);
    src_push(1, 1'b1, dd[1]); src_push(2, 1'b1, dd[2]); src_push(3, 1'b1, dd[3]);
    exp_push(0, dd[0]); exp_push(1, dd[1]); exp_push(2, dd[2]);
    exp_push(3, dd[3]); exp_push(0, dd[4]);
    wait_idle("t2_idle", 800);
    check("t2_starts", 32'(start_cnt - s0), 5);

    // requester 2 streams 20 bytes, requester 3 waits for forced rotation
    s0 = start_cnt;
    for (int i = 0; i < 21; i++) dd[i] = DW'($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) src_push(2, 1'b0, dd[i]);
    src_push(3, 1'b1, dd[20]);
    for (int i = 0; i < 16; i++) exp_push(2, dd[i]);
    exp_push(3, dd[20]);
    for (int i = 16; i < 20; i++) exp_push(2, dd[i]);
    wait_idle("t3_idle", 2500);
    check("t3_starts", 32'(start_cnt - s0), 21);

    // requester 1 stalls after 3 bytes without last
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      dd[i] = DW'($urandom_range(0, 255));
      src_push(1, 1'b0, dd[i]); exp_push(1, dd[i]);
    end
    found = 1'b0; n = 0;
    while (n < 600 && !found) begin
      @(negedge clk); n++;
      found = (dbg_state == SEND) && !req_valid[1] && grant_active && (exp_q.size() == 0);
    end
    check("t4_stall_seen", 32'(found), 1);
    @(negedge clk);
    check("t4_released", 32'(grant_active), 0);
    wait_idle("t4_idle", 100);
    repeat (30) @(negedge clk);
    check("t4_starts", 32'(start_cnt - s0), 3);

    // reset during WAIT_DONE
    dd[0] = DW'($urandom_range(1, 255));
    src_push(2, 1'b1, dd[0]); exp_push(2, dd[0]);
    n = 0;
    while (n < 40 && !tx_busy) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t5_in_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    rst_n = 1'b0;
    #1;
    check("t5_tx_start", 32'(tx_start), 0);
    check("t5_tx_data", 32'(tx_data), 0);
    check("t5_req_ready", 32'(req_ready), 0);
    check("t5_grant_id", 32'(grant_id), 0);
    check("t5_grant_active", 32'(grant_active), 0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    n = 0;
    while (n < 50 && tx_busy) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dd[1] = DW'($urandom_range(0, 255)); dd[2] = DW'($urandom_range(0, 255));
    src_push(3, 1'b1, dd[1]); src_push(0, 1'b1, dd[2]);
    exp_push(0, dd[2]); exp_push(3, dd[1]);
    wait_idle("t5_idle", 400);

    // long busy: no accepts while the datapath is occupied
    long_busy = 1'b1;
    dd[0] = DW'($urandom_range(0, 255)); dd[1] = DW'($urandom_range(0, 255));
    src_push(1, 1'b0, dd[0]); src_push(1, 1'b1, dd[1]);
    exp_push(1, dd[0]); exp_push(1, dd[1]);
    n = 0;
    while (n < 50 && !tx_busy) begin @(negedge clk); n++; end
    check("t6_busy_rise", 32'(tx_busy), 1);
    long_busy = 1'b0;
    r0 = ready_cnt; s0 = start_cnt;
    repeat (2500) @(negedge clk);
    check("t6_hold_state", 32'(dbg_state), 32'(WAIT_DONE));
    n = 0;
    while (n < 3000 && tx_busy) begin @(negedge clk); n++; end
    check("t6_busy_fall", 32'(tx_busy), 0);
    check("t6_no_ready", 32'(ready_cnt - r0), 0);
    check("t6_no_start", 32'(start_cnt - s0), 0);
    wait_idle("t6_idle", 400);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
